// File: rtl/dm_cache_pkg.sv
// Shared types and address-field geometry for the direct-mapped cache controller.
// Field positions are derived from the line/index geometry, so one set of helpers serves any configuration.
package dm_cache_pkg;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_INDEX_W        = 4;
    localparam int DEF_WORDS_PER_LINE = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        REFILL,
        RESPOND
    } state_t;

    function automatic int offset_w(input int words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int tag_w(input int addr_w, input int index_w, input int words_per_line);
        return addr_w - index_w - offset_w(words_per_line) - 2;
    endfunction

    // Bit positions of the word offset, index and tag inside a byte address.
    function automatic int word_lsb();
        return 2;
    endfunction

    function automatic int index_lsb(input int words_per_line);
        return word_lsb() + offset_w(words_per_line);
    endfunction

    function automatic int tag_lsb(input int index_w, input int words_per_line);
        return index_lsb(words_per_line) + index_w;
    endfunction

    localparam int OFFSET_W = offset_w(DEF_WORDS_PER_LINE);
    localparam int TAG_W    = tag_w(DEF_ADDR_W, DEF_INDEX_W, DEF_WORDS_PER_LINE);

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU load port and main-memory refill port of the cache controller.
// The slave modport is the controller's view; master is the CPU/memory side.
interface dm_cache_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_hit;
    logic              busy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  cpu_req, cpu_addr, mem_ack, mem_data,
        output cpu_ready, cpu_data, cpu_hit, busy, mem_req, mem_addr
    );

    modport master (
        output cpu_req, cpu_addr, mem_ack, mem_data,
        input  cpu_ready, cpu_data, cpu_hit, busy, mem_req, mem_addr
    );
endinterface

// File: rtl/dm_cache_store.sv
// Tag, valid and line-data arrays: one synchronous write port, combinational read.
// Only the valid bits are cleared by reset; tags and data come up undefined.
module dm_cache_store
    import dm_cache_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 24,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_word,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic                inv_en,
    input  logic                tag_we,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic                data_we,
    input  logic [OFFSET_W-1:0] wr_word,
    input  logic [DATA_W-1:0]   wr_data
);
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [DATA_W-1:0] data [LINES*WORDS];

    // Completing a refill wins over invalidation; the controller never asserts both together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[wr_index] <= 1'b1;
        end else if (inv_en) begin
            valid[wr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tags[wr_index] <= wr_tag;
        end
        if (data_we) begin
            data[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];
    assign rd_data  = data[{rd_index, rd_word}];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller: hit lookup and in-order multi-word line refill.
// Define DM_CACHE_STATS_EN to add saturating 16-bit hit_cnt/miss_cnt outputs.
module dm_cache_ctrl
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int INDEX_W        = DEF_INDEX_W,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  rst,
    dm_cache_ctrl_if.slave        bus
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [15:0]           hit_cnt,
    output logic [15:0]           miss_cnt
`endif
);
    localparam int LINE_OFF_W = offset_w(WORDS_PER_LINE);
    localparam int LINE_TAG_W = tag_w(ADDR_W, INDEX_W, WORDS_PER_LINE);
    localparam int IDX_LSB    = index_lsb(WORDS_PER_LINE);
    localparam int TAG_LSB    = tag_lsb(INDEX_W, WORDS_PER_LINE);

    state_t                  state;
    logic [ADDR_W-1:0]       addr_q;
    logic [LINE_OFF_W-1:0]   beat;
    logic                    ready_q;
    logic                    hit_q;
    logic                    busy_q;
    logic                    mem_req_q;
    logic [DATA_W-1:0]       data_q;
    logic [ADDR_W-1:0]       mem_addr_q;

    logic [INDEX_W-1:0]      req_index;
    logic [LINE_TAG_W-1:0]   req_tag;
    logic [LINE_OFF_W-1:0]   req_word;
    logic [LINE_OFF_W-1:0]   next_beat;
    logic                    rd_valid;
    logic [LINE_TAG_W-1:0]   rd_tag;
    logic [DATA_W-1:0]       rd_data;
    logic                    hit;
    logic                    last_beat;
    logic                    inv_en;
    logic                    data_we;
    logic                    tag_we;
    logic                    unused_byte_bits;

    assign req_index        = addr_q[IDX_LSB +: INDEX_W];
    assign req_tag          = addr_q[TAG_LSB +: LINE_TAG_W];
    assign req_word         = addr_q[word_lsb() +: LINE_OFF_W];
    assign unused_byte_bits = ^addr_q[1:0];
    assign next_beat        = beat + LINE_OFF_W'(1);

    assign hit       = rd_valid && (rd_tag == req_tag);
    assign last_beat = &beat;
    assign inv_en    = (state == LOOKUP) && !hit;
    assign data_we   = (state == REFILL) && bus.mem_ack;
    assign tag_we    = data_we && last_beat;

    dm_cache_store #(
        .DATA_W   (DATA_W),
        .TAG_W    (LINE_TAG_W),
        .INDEX_W  (INDEX_W),
        .OFFSET_W (LINE_OFF_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index),
        .rd_word  (req_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_index (req_index),
        .inv_en   (inv_en),
        .tag_we   (tag_we),
        .wr_tag   (req_tag),
        .data_we  (data_we),
        .wr_word  (beat),
        .wr_data  (bus.mem_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            beat       <= '0;
            ready_q    <= 1'b0;
            hit_q      <= 1'b0;
            busy_q     <= 1'b0;
            mem_req_q  <= 1'b0;
            data_q     <= '0;
            mem_addr_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        addr_q <= bus.cpu_addr;
                        busy_q <= 1'b1;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        hit_q   <= 1'b1;
                        ready_q <= 1'b1;
                        data_q  <= rd_data;
                        state   <= RESPOND;
                    end else begin
                        beat       <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {req_tag, req_index, {LINE_OFF_W{1'b0}}, 2'b00};
                        state      <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        beat <= next_beat;
                        if (last_beat) begin
                            // The requested word may be the one arriving right now.
                            mem_req_q <= 1'b0;
                            hit_q     <= 1'b0;
                            ready_q   <= 1'b1;
                            data_q    <= (beat == req_word) ? bus.mem_data : rd_data;
                            state     <= RESPOND;
                        end else begin
                            mem_addr_q <= {req_tag, req_index, next_beat, 2'b00};
                        end
                    end
                end
                RESPOND: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = ready_q;
    assign bus.cpu_hit   = hit_q;
    assign bus.cpu_data  = data_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = mem_addr_q;

`ifdef DM_CACHE_STATS_EN
    // Counted on the response cycle, so an aborted refill never contributes.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RESPOND) begin
            if (hit_q && (hit_cnt != 16'hFFFF)) begin
                hit_cnt <= hit_cnt + 16'd1;
            end
            if (!hit_q && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed self-checking bench for dm_cache_ctrl; memory data per beat is base + beat index.
// Stats counters are checked when DM_CACHE_STATS_EN is defined.
module tb_dm_cache_ctrl;

    logic clk;
    logic rst;

    dm_cache_ctrl_if bus ();

`ifdef DM_CACHE_STATS_EN
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;
`endif

    dm_cache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef DM_CACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int          ready_cnt;
    int          acks;
    int          bad_addr;
    int          req_drop;
    int          mem_seen;
    int          latency;
    logic        hit_seen;
    logic [31:0] data_seen;
    logic        busy_after;
    logic        post_busy;
    logic        abort_req;
    logic        abort_busy;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // One CPU read with a memory responder that waits 'gap' cycles before each ack.
    task automatic applyStimulus(input logic [31:0] addr, input int gap, input logic [31:0] base,
                                 input int abort_after, input bit poke);
        int          cyc;
        int          wait_cnt;
        int          post;
        bit          aborted;
        logic [31:0] line_base;
        ready_cnt = 0; acks = 0; bad_addr = 0; req_drop = 0; mem_seen = 0; latency = -1;
        hit_seen = 1'b0; data_seen = '0; abort_req = 1'b1; abort_busy = 1'b1;
        aborted = 1'b0; wait_cnt = 0; post = -1;
        line_base = {addr[31:4], 4'h0};
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = addr;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        busy_after  = bus.busy;
        cyc = 1;
        while (cyc < 200 && post != 0) begin
            if (abort_after > 0 && acks == abort_after && !aborted) begin
                bus.mem_ack = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                abort_req  = bus.mem_req;
                abort_busy = bus.busy;
                aborted = 1'b1;
                post = 6;
                cyc++;
            end
            if (bus.cpu_ready) begin
                ready_cnt++;
                if (latency < 0) begin
                    latency   = cyc;
                    hit_seen  = bus.cpu_hit;
                    data_seen = bus.cpu_data;
                    post      = 4;
                end
            end
            bus.mem_ack = 1'b0;
            if (bus.mem_req) begin
                mem_seen++;
                if (bus.mem_addr != line_base + 32'(acks * 4)) bad_addr++;
                if (wait_cnt >= gap) begin
                    bus.mem_ack  = 1'b1;
                    bus.mem_data = base + 32'(acks);
                    acks++;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (mem_seen > 0 && acks < 4 && !aborted) begin
                req_drop++;
            end
            if (poke && cyc == 4) begin
                bus.cpu_req  = 1'b1;
                bus.cpu_addr = 32'h300;
            end else begin
                bus.cpu_req = 1'b0;
            end
            if (post > 0) post--;
            @(negedge clk);
            cyc++;
        end
        bus.mem_ack = 1'b0;
        bus.cpu_req = 1'b0;
        post_busy   = bus.busy;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        rst = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_data = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_cpu_ready", 32'(bus.cpu_ready), 0);
        checkOutput("rst_busy",      32'(bus.busy), 0);
        checkOutput("rst_mem_req",   32'(bus.mem_req), 0);
        checkOutput("rst_mem_addr",  bus.mem_addr, 0);
        checkOutput("rst_cpu_data",  bus.cpu_data, 0);
        checkOutput("rst_cpu_hit",   32'(bus.cpu_hit), 0);
        rst = 1'b0;

        $display("[TB] cold miss 0x5F");
        applyStimulus(32'h5F, 1, 32'hA0, 0, 1'b0);
        checkOutput("cold_busy",     32'(busy_after), 1);
        checkOutput("cold_ready",    ready_cnt, 1);
        checkOutput("cold_hit",      32'(hit_seen), 0);
        checkOutput("cold_data",     data_seen, 32'hA3);
        checkOutput("cold_acks",     acks, 4);
        checkOutput("cold_addr_seq", bad_addr, 0);
        checkOutput("cold_req_held", req_drop, 0);
        checkOutput("cold_idle",     32'(post_busy), 0);

        $display("[TB] repeated hits 0x5F");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h5F, 0, 32'h0, 0, 1'b0);
            checkOutput("hit_flag",    32'(hit_seen), 1);
            checkOutput("hit_data",    data_seen, 32'hA3);
            checkOutput("hit_latency", latency, 2);
            checkOutput("hit_no_mem",  mem_seen, 0);
            checkOutput("hit_ready",   ready_cnt, 1);
        end
`ifdef DM_CACHE_STATS_EN
        checkOutput("stats_hits",   32'(hit_cnt), 5);
        checkOutput("stats_misses", 32'(miss_cnt), 1);
`endif

        $display("[TB] conflict eviction 0x45F then 0x5F");
        applyStimulus(32'h45F, 0, 32'hB0, 0, 1'b0);
        checkOutput("evict1_hit",  32'(hit_seen), 0);
        checkOutput("evict1_data", data_seen, 32'hB3);
        checkOutput("evict1_acks", acks, 4);
        checkOutput("evict1_addr", bad_addr, 0);
        applyStimulus(32'h5F, 0, 32'hC0, 0, 1'b0);
        checkOutput("evict2_hit",  32'(hit_seen), 0);
        checkOutput("evict2_data", data_seen, 32'hC3);
        checkOutput("evict2_acks", acks, 4);
        checkOutput("evict2_addr", bad_addr, 0);

        $display("[TB] stalled memory 0x124 with busy request poke");
        applyStimulus(32'h124, 3, 32'hD0, 0, 1'b1);
        checkOutput("stall_hit",      32'(hit_seen), 0);
        checkOutput("stall_data",     data_seen, 32'hD1);
        checkOutput("stall_ready",    ready_cnt, 1);
        checkOutput("stall_addr",     bad_addr, 0);
        checkOutput("stall_req_held", req_drop, 0);
        checkOutput("stall_acks",     acks, 4);
        checkOutput("poke_ignored",   32'(post_busy), 0);
`ifdef DM_CACHE_STATS_EN
        checkOutput("stats_hits2",   32'(hit_cnt), 5);
        checkOutput("stats_misses2", 32'(miss_cnt), 4);
`endif

        $display("[TB] reset mid-refill");
        applyStimulus(32'h45F, 1, 32'hF0, 2, 1'b0);
        checkOutput("abort_mem_req", 32'(abort_req), 0);
        checkOutput("abort_busy",    32'(abort_busy), 0);
        checkOutput("abort_ready",   ready_cnt, 0);
        checkOutput("abort_acks",    acks, 2);
        applyStimulus(32'h5F, 0, 32'hE0, 0, 1'b0);
        checkOutput("post_abort_hit",  32'(hit_seen), 0);
        checkOutput("post_abort_data", data_seen, 32'hE3);
        checkOutput("post_abort_acks", acks, 4);
`ifdef DM_CACHE_STATS_EN
        checkOutput("stats_hits3",   32'(hit_cnt), 0);
        checkOutput("stats_misses3", 32'(miss_cnt), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
